// File: rtl/motor_pwm_mmio.sv
// ============================================================================
// Module  : motor_pwm_mmio
// Brief   : Memory-mapped dual-channel PWM motor controller with watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module motor_pwm_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter logic [15:0] PERIOD_RST = 16'd1000,
    parameter logic [23:0] WDT_RST    = 24'd50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bus_addr_i,
    input  logic [31:0] bus_wdata_i,
    input  logic        bus_wen_i,
    output logic [31:0] bus_rdata_o,
    output logic        pwm_l_o,
    output logic        pwm_r_o,
    output logic        dir_l_o,
    output logic        dir_r_o,
    output logic        wdt_trip_o
);

    localparam logic [5:0] c_idx_ctrl   = 6'h00;
    localparam logic [5:0] c_idx_period = 6'h01;
    localparam logic [5:0] c_idx_duty_l = 6'h02;
    localparam logic [5:0] c_idx_duty_r = 6'h03;
    localparam logic [5:0] c_idx_wdt    = 6'h04;
    localparam logic [5:0] c_idx_status = 6'h05;
    localparam logic [5:0] c_idx_count  = 6'h06;

    logic [3:0]  ctrl_q,     ctrl_d;
    logic [15:0] period_q,   period_d;
    logic [15:0] duty_l_q,   duty_l_d;
    logic [15:0] duty_r_q,   duty_r_d;
    logic [23:0] wdt_load_q, wdt_load_d;
    logic [23:0] wdt_cnt_q,  wdt_cnt_d;
    logic        trip_q,     trip_d;
    logic [15:0] count_q,    count_d;
    logic [15:0] period_a_q, period_a_d;
    logic [15:0] duty_l_a_q, duty_l_a_d;
    logic [15:0] duty_r_a_q, duty_r_a_d;
    logic        pwm_l_q,    pwm_l_d;
    logic        pwm_r_q,    pwm_r_d;

    logic        w_sel;
    logic [5:0]  w_idx;
    logic        w_wr;
    logic        w_kick;
    logic        w_clear;
    logic        w_idle;
    logic        unused_bits;

    assign w_sel   = (bus_addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_idx   = bus_addr_i[7:2];
    assign w_wr    = w_sel & bus_wen_i;
    assign w_kick  = w_wr & ((w_idx == c_idx_ctrl) | (w_idx == c_idx_duty_l) |
                             (w_idx == c_idx_duty_r));
    assign w_clear = w_wr & (w_idx == c_idx_status) & bus_wdata_i[0];
    assign w_idle  = ~ctrl_q[0] | trip_q | (period_a_q == 16'd0);

    assign unused_bits = ^{bus_addr_i[1:0], bus_wdata_i[31:24]};

    always_comb begin
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        duty_l_d   = duty_l_q;
        duty_r_d   = duty_r_q;
        wdt_load_d = wdt_load_q;
        if (w_wr) begin
            case (w_idx)
                c_idx_ctrl:   ctrl_d     = bus_wdata_i[3:0];
                c_idx_period: period_d   = bus_wdata_i[15:0];
                c_idx_duty_l: duty_l_d   = bus_wdata_i[15:0];
                c_idx_duty_r: duty_r_d   = bus_wdata_i[15:0];
                c_idx_wdt:    wdt_load_d = bus_wdata_i[23:0];
                default:      ;
            endcase
        end
    end

    // Clear beats kick beats expiry, so a refresh on the expiry edge never trips.
    always_comb begin
        trip_d    = trip_q;
        wdt_cnt_d = wdt_cnt_q;
        if (w_clear) begin
            trip_d    = 1'b0;
            wdt_cnt_d = wdt_load_q;
        end else if (w_kick) begin
            wdt_cnt_d = wdt_load_q;
        end else if (ctrl_q[3] && !trip_q && (wdt_cnt_q != 24'd0)) begin
            wdt_cnt_d = wdt_cnt_q - 24'd1;
            if (wdt_cnt_q == 24'd1) begin
                trip_d = 1'b1;
            end
        end
    end

    // Actives reload from the pre-write shadows, deferring a boundary-edge write.
    always_comb begin
        count_d    = count_q;
        period_a_d = period_a_q;
        duty_l_a_d = duty_l_a_q;
        duty_r_a_d = duty_r_a_q;
        pwm_l_d    = 1'b0;
        pwm_r_d    = 1'b0;
        if (w_idle) begin
            count_d    = 16'd0;
            period_a_d = period_q;
            duty_l_a_d = duty_l_q;
            duty_r_a_d = duty_r_q;
        end else begin
            pwm_l_d = (count_q < duty_l_a_q);
            pwm_r_d = (count_q < duty_r_a_q);
            if (count_q >= period_a_q - 16'd1) begin
                count_d    = 16'd0;
                period_a_d = period_q;
                duty_l_a_d = duty_l_q;
                duty_r_a_d = duty_r_q;
            end else begin
                count_d = count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 4'd0;
            period_q   <= PERIOD_RST;
            duty_l_q   <= 16'd0;
            duty_r_q   <= 16'd0;
            wdt_load_q <= WDT_RST;
            wdt_cnt_q  <= WDT_RST;
            trip_q     <= 1'b0;
            count_q    <= 16'd0;
            period_a_q <= 16'd0;
            duty_l_a_q <= 16'd0;
            duty_r_a_q <= 16'd0;
            pwm_l_q    <= 1'b0;
            pwm_r_q    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            duty_l_q   <= duty_l_d;
            duty_r_q   <= duty_r_d;
            wdt_load_q <= wdt_load_d;
            wdt_cnt_q  <= wdt_cnt_d;
            trip_q     <= trip_d;
            count_q    <= count_d;
            period_a_q <= period_a_d;
            duty_l_a_q <= duty_l_a_d;
            duty_r_a_q <= duty_r_a_d;
            pwm_l_q    <= pwm_l_d;
            pwm_r_q    <= pwm_r_d;
        end
    end

    always_comb begin
        bus_rdata_o = 32'd0;
        if (w_sel) begin
            case (w_idx)
                c_idx_ctrl:   bus_rdata_o = {28'd0, ctrl_q};
                c_idx_period: bus_rdata_o = {16'd0, period_q};
                c_idx_duty_l: bus_rdata_o = {16'd0, duty_l_q};
                c_idx_duty_r: bus_rdata_o = {16'd0, duty_r_q};
                c_idx_wdt:    bus_rdata_o = {8'd0, wdt_load_q};
                c_idx_status: bus_rdata_o = {31'd0, trip_q};
                c_idx_count:  bus_rdata_o = {16'd0, count_q};
                default:      bus_rdata_o = 32'd0;
            endcase
        end
    end

    assign pwm_l_o    = pwm_l_q;
    assign pwm_r_o    = pwm_r_q;
    assign dir_l_o    = ctrl_q[1];
    assign dir_r_o    = ctrl_q[2];
    assign wdt_trip_o = trip_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_pwm_mmio.sv
// ============================================================================
// Module  : tb_motor_pwm_mmio
// Brief   : Scoreboard-driven bench for motor_pwm_mmio.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_motor_pwm_mmio;

    localparam logic [31:0] BASE    = 32'h4000_0000;
    localparam logic [23:0] WDT_DEF = 24'd50_000_000;

    localparam logic [7:0] O_CTRL   = 8'h00;
    localparam logic [7:0] O_PERIOD = 8'h04;
    localparam logic [7:0] O_DUTY_L = 8'h08;
    localparam logic [7:0] O_DUTY_R = 8'h0C;
    localparam logic [7:0] O_WDT    = 8'h10;
    localparam logic [7:0] O_STATUS = 8'h14;
    localparam logic [7:0] O_COUNT  = 8'h18;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wen   = 1'b0;
    logic [31:0] rdata;
    logic        pwm_l, pwm_r, dir_l, dir_r, trip;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    motor_pwm_mmio dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_addr_i (addr),
        .bus_wdata_i(wdata),
        .bus_wen_i  (wen),
        .bus_rdata_o(rdata),
        .pwm_l_o    (pwm_l),
        .pwm_r_o    (pwm_r),
        .dir_l_o    (dir_l),
        .dir_r_o    (dir_r),
        .wdt_trip_o (trip)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // Called at a falling edge; the write lands on the next rising edge.
    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        addr  = BASE | {24'd0, off};
        wdata = d;
        wen   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wen   = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
        addr = BASE | {24'd0, off};
        #1;
        d = rdata;
    endtask

    task automatic wait_count(input logic [15:0] v, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_read(O_COUNT, d);
            if (d[15:0] == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        for (int p = 0; p < 2; p++) begin
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd1000);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            exp_q.push_back({8'd0, WDT_DEF});
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            for (int i = 0; i < 8; i++) begin
                bus_read(8'(i * 4), d);
                e = exp_q.pop_front();
                checks++;
                if (d !== e) begin
                    failures++;
                    $display("FAIL reset_reg pass=%0d off=%0h actual=%0h required=%0h", p, i * 4, d, e);
                end
            end
            checks++;
            if ({pwm_l, pwm_r, dir_l, dir_r, trip} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs actual=%b required=00000", {pwm_l, pwm_r, dir_l, dir_r, trip});
            end
            if (p == 0) begin
                @(negedge clk);
                addr  = BASE + 32'h100;
                wdata = 32'hFFFF_FFFF;
                wen   = 1'b1;
                #1;
                checks++;
                if (rdata !== 32'd0) begin
                    failures++;
                    $display("FAIL unselected_read actual=%0h required=0", rdata);
                end
                @(posedge clk);
                @(negedge clk);
                wen = 1'b0;
                bus_write(8'h1C, 32'hFFFF_FFFF);
                bus_write(8'h40, 32'hFFFF_FFFF);
            end
        end
    endtask

    task automatic test_pwm();
        logic [31:0] d, e, o;
        bus_write(O_PERIOD, 32'd10);
        bus_write(O_DUTY_L, 32'd3);
        bus_write(O_DUTY_R, 32'd10);
        bus_write(O_CTRL, 32'd1);
        for (int k = 0; k <= 30; k++) begin
            e = {14'd0, (k > 0) && (((k - 1) % 10) < 3), (k > 0), 16'(k % 10)};
            exp_q.push_back(e);
        end
        for (int k = 0; k <= 30; k++) begin
            if (k > 0) @(negedge clk);
            bus_read(O_COUNT, d);
            o = {14'd0, pwm_l, pwm_r, d[15:0]};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pwm_run k=%0d actual=%0h required=%0h", k, o, e);
            end
        end
    endtask

    task automatic test_shadow_update();
        logic [31:0] d, e, o;
        bit ok;
        int c, du;
        wait_count(16'd4, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_count4 actual=timeout required=count4");
        end
        bus_write(O_DUTY_L, 32'd7);
        for (int j = 0; j < 25; j++) begin
            c  = (5 + j) % 10;
            du = (j <= 5) ? 3 : 7;
            exp_q.push_back({14'd0, (((c + 9) % 10) < du), 1'b1, 16'(c)});
        end
        for (int j = 0; j < 25; j++) begin
            if (j > 0) @(negedge clk);
            bus_read(O_COUNT, d);
            o = {14'd0, pwm_l, pwm_r, d[15:0]};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL shadow_mid j=%0d actual=%0h required=%0h", j, o, e);
            end
        end
        wait_count(16'd9, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wait_count9 actual=timeout required=count9");
        end
        bus_write(O_DUTY_L, 32'd2);
        for (int j = 0; j < 30; j++) begin
            c  = j % 10;
            du = (j <= 10) ? 7 : 2;
            exp_q.push_back({14'd0, (((c + 9) % 10) < du), 1'b1, 16'(c)});
        end
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            bus_read(O_COUNT, d);
            o = {14'd0, pwm_l, pwm_r, d[15:0]};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL shadow_boundary j=%0d actual=%0h required=%0h", j, o, e);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] d, e;
        bus_write(O_DUTY_L, 32'd3);
        bus_write(O_WDT, 32'd20);
        bus_write(O_CTRL, 32'h9);
        for (int k = 1; k <= 22; k++) exp_q.push_back({31'd0, (k >= 20)});
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, trip} !== e) begin
                failures++;
                $display("FAIL wdt_trip k=%0d actual=%b required=%0d", k, trip, e);
            end
            if (k >= 21) begin
                checks++;
                if ({pwm_l, pwm_r} !== 2'b00) begin
                    failures++;
                    $display("FAIL wdt_pwm_off k=%0d actual=%b required=00", k, {pwm_l, pwm_r});
                end
            end
        end
        bus_read(O_STATUS, d);
        checks++;
        if (d !== 32'd1) begin
            failures++;
            $display("FAIL status_read actual=%0h required=1", d);
        end
        bus_write(O_STATUS, 32'd1);
        bus_read(O_COUNT, d);
        checks++;
        if ({trip, d[15:0]} !== 17'd0) begin
            failures++;
            $display("FAIL status_clear actual=trip%b cnt%0d required=trip0 cnt0", trip, d[15:0]);
        end
        @(negedge clk);
        bus_read(O_COUNT, d);
        checks++;
        if ({pwm_l, d[15:0]} !== {1'b1, 16'd1}) begin
            failures++;
            $display("FAIL pwm_resume actual=pwm%b cnt%0d required=pwm1 cnt1", pwm_l, d[15:0]);
        end
        for (int n = 0; n < 7; n++) begin
            repeat (14) @(negedge clk);
            checks++;
            if (trip !== 1'b0) begin
                failures++;
                $display("FAIL kick_refresh n=%0d actual=%b required=0", n, trip);
            end
            bus_write(O_DUTY_L, 32'd3);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        repeat (19) @(negedge clk);
        bus_write(O_DUTY_L, 32'd3);
        checks++;
        if (trip !== 1'b0) begin
            failures++;
            $display("FAIL kick_on_expiry actual=%b required=0", trip);
        end
        repeat (19) @(negedge clk);
        bus_write(O_STATUS, 32'd1);
        checks++;
        if (trip !== 1'b0) begin
            failures++;
            $display("FAIL clear_on_expiry actual=%b required=0", trip);
        end
        for (int m = 1; m <= 20; m++) exp_q.push_back({31'd0, (m == 20)});
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({31'd0, trip} !== e) begin
                failures++;
                $display("FAIL reload_after_clear m=%0d actual=%b required=%0d", m, trip, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d, e;
        bit ok;
        bus_write(O_STATUS, 32'd1);
        bus_write(O_CTRL, 32'h7);
        wait_count(16'd2, ok);
        checks++;
        if (!ok || pwm_l !== 1'b1 || {dir_l, dir_r} !== 2'b11) begin
            failures++;
            $display("FAIL pre_reset actual=ok%b pwm%b dir%b%b required=ok1 pwm1 dir11", ok, pwm_l, dir_l, dir_r);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pwm_l, pwm_r, dir_l, dir_r, trip, rdata[15:0]} !== 21'd0) begin
            failures++;
            $display("FAIL async_reset actual=%b cnt%0d required=00000 cnt0", {pwm_l, pwm_r, dir_l, dir_r, trip}, rdata[15:0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1000);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back({8'd0, WDT_DEF});
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        for (int i = 0; i < 7; i++) begin
            bus_read(8'(i * 4), d);
            e = exp_q.pop_front();
            checks++;
            if (d !== e) begin
                failures++;
                $display("FAIL post_reset off=%0h actual=%0h required=%0h", i * 4, d, e);
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_pwm();
        test_shadow_update();
        test_watchdog();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
